unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

- Shares one single-port synchronous memory between the core's instruction-fetch requester and its data-memory requester.
- Sits between the multicycle core (fetch stage and memory stage) and the memory macro.
- Serialises accesses with round-robin or data-priority arbitration, a registered grant, and a fixed-latency completion strobe per requester.
- Serves one transaction at a time.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MEM_LATENCY, 1, cycles from the m_en cycle to the m_rdata-valid cycle; legal range 1..4
- DATA_PRIORITY, 0, 0 = round-robin on ties; 1 = data always wins ties

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  instruction read request; held high until i_gnt
- i_addr  in  ADDR_W  instruction address; stable while i_req is high
- i_gnt  out  1  one-cycle grant pulse for the instruction requester
- i_done  out  1  one-cycle pulse; i_rdata is valid in this cycle
- i_rdata  out  DATA_W  instruction word; 0 when i_done is low
- d_req  in  1  data request; held high until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_W/8  store byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle grant pulse for the data requester
- d_done  out  1  one-cycle completion pulse for loads and stores
- d_rdata  out  DATA_W  load data; 0 when d_done is low or on a store
- m_en  out  1  memory access strobe
- m_we  out  1  memory write enable
- m_be  out  DATA_W/8  memory byte enables
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after m_en

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples i_req and d_req; both are ignored in every other state.
  - If either is high, latches the winner's command into the m_* registers and goes to ISSUE.
  - Otherwise stays in IDLE.
- ISSUE:
  - m_en=1 and the winner's gnt=1 for exactly this cycle.
  - Goes to WAIT if MEM_LATENCY>1, else to RESP.
- WAIT:
  - Counter loads MEM_LATENCY-2 on entry and decrements each cycle.
  - Goes to RESP when the counter reaches 0.
  - Occupies MEM_LATENCY-1 cycles in total.
- RESP:
  - Owner's done=1; for reads, rdata = m_rdata (combinational pass-through).
  - Always returns to IDLE.
- Instruction command: m_we=0, m_be=all ones, m_addr=i_addr, m_wdata=0.
- Data command: m_we=d_we, m_be=d_be, m_addr=d_addr, m_wdata=d_wdata.
  - For a load, d_be is still forwarded; memory ignores it.
- Arbitration:
  - Single request: that requester wins.
  - Both requesting with DATA_PRIORITY=1: data wins.
  - Both requesting with DATA_PRIORITY=0: the requester not recorded in the last_winner register wins.
  - last_winner updates on every entry into ISSUE.
- Owner register records which requester holds the in-flight transaction; it steers done/rdata.
- Protocol rules:
  - A requester drops req in the cycle after seeing gnt, unless it has a new request.
  - A req dropped before its gnt is not served and raises no error.

## Timing
- Reset (asynchronous):
  - State IDLE, counter 0, last_winner=DATA, so the instruction requester wins the first tie.
  - All outputs 0.
  - An in-flight transaction is abandoned: no gnt or done is produced, and m_en drops immediately.
- Request sampled in IDLE at cycle N:
  - gnt and m_en in cycle N+1.
  - done in cycle N+1+MEM_LATENCY.
  - IDLE again in cycle N+2+MEM_LATENCY.
- Throughput: one transaction per MEM_LATENCY+2 cycles. A req raised during the done cycle is sampled in the following IDLE cycle.
- m_we, m_be, m_addr and m_wdata stay constant from ISSUE through RESP; they hold their last value in IDLE.
- i_done and d_done are never high in the same cycle; likewise i_gnt and d_gnt.
- A new req arriving in ISSUE, WAIT or RESP has no effect until IDLE.

## Test plan
- Reset, then i_req=1 with i_addr=0x100 at cycle 0, MEM_LATENCY=1 -> i_gnt and m_en (m_addr=0x100, m_we=0, m_be=4'hF) in cycle 1; i_done in cycle 2 with i_rdata equal to memory[0x100]; IDLE in cycle 3.
- Data store d_addr=0x2004, d_be=4'b0011, d_wdata=0xDEADBEEF -> m_we=1 with matching m_be and m_wdata in the ISSUE cycle; d_done one cycle later; d_rdata=0; memory shows 0x....BEEF.
- i_req and d_req held continuously, DATA_PRIORITY=0 -> grants alternate I, D, I, D; first grant goes to I; no cycle has both gnt signals high.
- Same stimulus with DATA_PRIORITY=1 -> every grant goes to D while d_req stays high; I is served only once d_req drops.
- MEM_LATENCY=3, data load -> m_en at N+1, d_done at N+4 carrying memory data; a req raised at N+2 is ignored until IDLE at N+5.
- Reset asserted in the WAIT state -> all outputs 0 immediately, no done for the abandoned transaction; the next tie after reset is won by I.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous memory between an instruction-fetch and a data requester.
// Latency: grant + m_en one cycle after the request is sampled in IDLE; done MEM_LATENCY cycles after that.
// Backpressure: one transaction in flight; requests are only sampled in IDLE and must be held until gnt.
module unified_mem_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MEM_LATENCY   = 1,
  parameter int DATA_PRIORITY = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_done,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_en,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata
);

  // WAIT lasts WAIT_LOAD+1 = MEM_LATENCY-1 cycles; unused when MEM_LATENCY is 1.
  localparam logic [1:0] WAIT_LOAD = (MEM_LATENCY > 2) ? 2'(MEM_LATENCY - 2) : 2'd0;
  localparam logic       REQ_I     = 1'b0;
  localparam logic       REQ_D     = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] cnt;
  logic       last_winner;
  logic       owner;
  logic       take;
  logic       win;

  // Next-state and arbitration: pick a winner and decide whether IDLE accepts a command.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    if (i_req && d_req) begin
      win = (DATA_PRIORITY != 0) ? REQ_D : ~last_winner;
    end else begin
      win = d_req ? REQ_D : REQ_I;
    end
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          take      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = (MEM_LATENCY > 1) ? WAIT : RESP;
      WAIT:    if (cnt == 2'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command latch, owner/last-winner tracking and the WAIT down-counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt         <= 2'd0;
      last_winner <= REQ_D;
      owner       <= REQ_I;
      m_we        <= 1'b0;
      m_be        <= '0;
      m_addr      <= '0;
      m_wdata     <= '0;
    end else begin
      if (take) begin
        owner       <= win;
        last_winner <= win;
        if (win == REQ_D) begin
          m_we    <= d_we;
          m_be    <= d_be;
          m_addr  <= d_addr;
          m_wdata <= d_wdata;
        end else begin
          m_we    <= 1'b0;
          m_be    <= '1;
          m_addr  <= i_addr;
          m_wdata <= '0;
        end
      end
      if (state == ISSUE) begin
        cnt <= WAIT_LOAD;
      end else if (state == WAIT && cnt != 2'd0) begin
        cnt <= cnt - 2'd1;
      end
    end
  end

  // Strobes decode straight from state so they drop the instant reset hits.
  assign m_en    = (state == ISSUE);
  assign i_gnt   = m_en && (owner == REQ_I);
  assign d_gnt   = m_en && (owner == REQ_D);
  assign i_done  = (state == RESP) && (owner == REQ_I);
  assign d_done  = (state == RESP) && (owner == REQ_D);
  assign i_rdata = i_done ? m_rdata : '0;
  assign d_rdata = (d_done && !m_we) ? m_rdata : '0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomised scoreboard bench for two arbiter configurations sharing one clock.
// dut0: MEM_LATENCY=1, DATA_PRIORITY=1.  dut1: MEM_LATENCY=3, DATA_PRIORITY=0.
// A transaction-level model predicts grants/completions; a negedge monitor pops and compares.
module tb_unified_mem_arbiter;

  typedef struct {
    int          cyc;
    logic        who;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst     [2];
  logic        i_req   [2];
  logic [31:0] i_addr  [2];
  logic        i_gnt   [2];
  logic        i_done  [2];
  logic [31:0] i_rdata [2];
  logic        d_req   [2];
  logic        d_we    [2];
  logic [3:0]  d_be    [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];
  logic        d_gnt   [2];
  logic        d_done  [2];
  logic [31:0] d_rdata [2];
  logic        m_en    [2];
  logic        m_we    [2];
  logic [3:0]  m_be    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .DATA_PRIORITY(1)) dut0 (
    .clock(clock), .reset(rst[0]),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_gnt(i_gnt[0]), .i_done(i_done[0]), .i_rdata(i_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_be(d_be[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_gnt(d_gnt[0]), .d_done(d_done[0]), .d_rdata(d_rdata[0]),
    .m_en(m_en[0]), .m_we(m_we[0]), .m_be(m_be[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
    .m_rdata(m_rdata[0])
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .DATA_PRIORITY(0)) dut1 (
    .clock(clock), .reset(rst[1]),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_gnt(i_gnt[1]), .i_done(i_done[1]), .i_rdata(i_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_be(d_be[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_gnt(d_gnt[1]), .d_done(d_done[1]), .d_rdata(d_rdata[1]),
    .m_en(m_en[1]), .m_we(m_we[1]), .m_be(m_be[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
    .m_rdata(m_rdata[1])
  );

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int dp_of(int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic logic [31:0] init_word(int a);
    return 32'h1357_9BDF ^ (32'(a) * 32'h0101_0101);
  endfunction

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   free_at [2];
  logic last_d  [2];
  txn_t gq [2][$];
  txn_t dq [2][$];
  logic [31:0] shadow [2][256];
  logic [31:0] mem    [2][256];
  logic [31:0] pipe   [2][4];

  task automatic check(string name, int k, logic [159:0] act, logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d: got %h want %h", name, k, cyc, act, exp);
    end
  endtask

  // Memory macro: byte-masked writes, read data delayed MEM_LATENCY cycles after m_en.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        for (int a = 0; a < 256; a++) mem[k][a] <= init_word(a);
        for (int s = 0; s < 4; s++) pipe[k][s] <= '0;
      end else begin
        if (m_en[k]) begin
          pipe[k][0] <= mem[k][m_addr[k][9:2]];
          if (m_we[k]) begin
            for (int b = 0; b < 4; b++)
              if (m_be[k][b]) mem[k][m_addr[k][9:2]][8*b +: 8] <= m_wdata[k][8*b +: 8];
          end
        end else begin
          pipe[k][0] <= '0;
        end
        for (int s = 1; s < 4; s++) pipe[k][s] <= pipe[k][s-1];
      end
    end
  end
  assign m_rdata[0] = pipe[0][0];
  assign m_rdata[1] = pipe[1][2];

  // Reference model: whenever the arbiter is free, pick a winner and schedule its grant and completion.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        gq[k].delete();
        dq[k].delete();
        last_d[k]  = 1'b1;
        free_at[k] = 0;
        for (int a = 0; a < 256; a++) shadow[k][a] = init_word(a);
      end else if (cyc >= free_at[k] && (i_req[k] || d_req[k])) begin
        txn_t t;
        int   idx;
        if (i_req[k] && d_req[k]) t.who = (dp_of(k) != 0) ? 1'b1 : ~last_d[k];
        else                      t.who = d_req[k];
        if (t.who) begin
          t.we = d_we[k]; t.be = d_be[k]; t.addr = d_addr[k]; t.wdata = d_wdata[k];
        end else begin
          t.we = 1'b0; t.be = 4'hF; t.addr = i_addr[k]; t.wdata = 32'h0;
        end
        idx     = int'(t.addr[9:2]);
        t.rdata = t.we ? 32'h0 : shadow[k][idx];
        if (t.we) begin
          for (int b = 0; b < 4; b++)
            if (t.be[b]) shadow[k][idx][8*b +: 8] = t.wdata[8*b +: 8];
        end
        t.cyc = cyc + 1;
        gq[k].push_back(t);
        t.cyc = cyc + 1 + lat_of(k);
        dq[k].push_back(t);
        last_d[k]  = t.who;
        free_at[k] = cyc + 2 + lat_of(k);
      end
    end
    cyc++;
  end

  // Monitor: compare DUT strobes/data against the scheduled expectations every cycle.
  always @(negedge clock) begin
    txn_t t;
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        check("reset_outputs_zero", k,
              160'({i_gnt[k], i_done[k], i_rdata[k], d_gnt[k], d_done[k], d_rdata[k],
                    m_en[k], m_we[k], m_be[k], m_addr[k], m_wdata[k]}), '0);
      end else begin
        if (gq[k].size() > 0 && gq[k][0].cyc == cyc) begin
          t = gq[k].pop_front();
          check("grant", k,
                160'({i_gnt[k], d_gnt[k], m_en[k], m_we[k], m_be[k], m_addr[k], m_wdata[k]}),
                160'({~t.who, t.who, 1'b1, t.we, t.be, t.addr, t.wdata}));
        end else begin
          check("no_grant", k, 160'({i_gnt[k], d_gnt[k], m_en[k]}), '0);
        end
        if (dq[k].size() > 0 && dq[k][0].cyc == cyc) begin
          t = dq[k].pop_front();
          check("done", k,
                160'({i_done[k], d_done[k], i_rdata[k], d_rdata[k], m_we[k], m_be[k], m_addr[k], m_wdata[k]}),
                160'({~t.who, t.who, (t.who ? 32'h0 : t.rdata), (t.who ? t.rdata : 32'h0),
                      t.we, t.be, t.addr, t.wdata}));
        end else begin
          check("no_done", k, 160'({i_done[k], d_done[k], i_rdata[k], d_rdata[k]}), '0);
        end
      end
    end
  end

  task automatic new_i(int k);
    i_req[k]  = 1'b1;
    i_addr[k] = $urandom & 32'h0000_03FC;
  endtask

  task automatic new_d(int k);
    d_req[k]   = 1'b1;
    d_we[k]    = 1'($urandom);
    d_be[k]    = 4'($urandom);
    d_addr[k]  = $urandom & 32'h0000_03FC;
    d_wdata[k] = $urandom;
  endtask

  // One negedge worth of requester behaviour: drop or renew after gnt, raise, or withdraw.
  task automatic drive(int pi, int pd, int pw);
    for (int k = 0; k < 2; k++) begin
      if (i_req[k] && i_gnt[k]) begin
        if (int'($urandom_range(99)) < pi) new_i(k); else i_req[k] = 1'b0;
      end else if (!i_req[k]) begin
        if (int'($urandom_range(99)) < pi) new_i(k);
      end else if (int'($urandom_range(99)) < pw) begin
        i_req[k] = 1'b0;
      end
      if (d_req[k] && d_gnt[k]) begin
        if (int'($urandom_range(99)) < pd) new_d(k); else d_req[k] = 1'b0;
      end else if (!d_req[k]) begin
        if (int'($urandom_range(99)) < pd) new_d(k);
      end else if (int'($urandom_range(99)) < pw) begin
        d_req[k] = 1'b0;
      end
    end
  endtask

  task automatic run(int n, int pi, int pd, int pw);
    repeat (n) begin
      @(negedge clock);
      drive(pi, pd, pw);
    end
  endtask

  initial begin
    logic        found;
    logic [31:0] w1;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; i_req[k] = 1'b0; i_addr[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_be[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    #1;
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    repeat (3) @(negedge clock);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Lone fetch from 0x100, then a half-word store to 0x2004.
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b1; i_addr[k] = 32'h100;
    end
    run(6, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      d_req[k] = 1'b1; d_we[k] = 1'b1; d_be[k] = 4'b0011;
      d_addr[k] = 32'h2004; d_wdata[k] = 32'hDEAD_BEEF;
    end
    run(8, 0, 0, 0);
    w1 = init_word(1);
    for (int k = 0; k < 2; k++)
      check("store_bytes", k, 160'(mem[k][1]), 160'({w1[31:16], 16'hBEEF}));

    // Load back the stored word; a fetch raised mid-transaction waits for IDLE.
    for (int k = 0; k < 2; k++) begin
      d_req[k] = 1'b1; d_we[k] = 1'b0; d_be[k] = 4'hF; d_addr[k] = 32'h2004;
    end
    run(2, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b1; i_addr[k] = 32'h40;
    end
    run(12, 0, 0, 0);

    // Both requesters held: alternation on dut1, data wins every tie on dut0.
    run(40, 100, 100, 0);
    // Data stops renewing: starved fetches get served.
    run(20, 100, 0, 0);
    run(400, 40, 40, 10);

    // Reset dut1 while it sits in WAIT, with a tie pending for the first post-reset IDLE.
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clock);
      drive(40, 40, 0);
      if (i_gnt[1] || d_gnt[1]) found = 1'b1;
    end
    check("reset_in_wait_reached", 1, 160'(found), 160'(1));
    if (found) begin
      @(posedge clock);
      #2;
      rst[1] = 1'b1;
      new_i(1);
      new_d(1);
      run(3, 40, 40, 0);
      rst[1] = 1'b0;
    end

    run(200, 40, 40, 10);
    run(40, 0, 0, 0);
    for (int k = 0; k < 2; k++)
      check("queues_drained", k, 160'(gq[k].size() + dq[k].size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
